// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller for the 5-stage RV32I core
//
// Purpose:
//   Generates the pipeline register enables and flushes, and the EX-stage
//   operand forwarding selects. It handles load-use stalls, EX-resolved
//   redirects and data-memory wait states. It also keeps saturating
//   stall/redirect counters and a sticky dmem timeout flag.
//
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   rs1/rs2_ID, rs1/rs2_used_ID     source operands of the ID instruction
//   rs1/rs2_EX, rd_EX, RegWEn_EX,
//   WBSel_EX, PCSel_EX              EX instruction info and redirect
//   rd_MEM, RegWEn_MEM              MEM destination
//   rd_WB, RegWEn_WB                WB destination
//   dmem_req, dmem_ready            data memory handshake
//   pc_en, en_*, flush_*            pipeline control (combinational)
//   fwdA_EX, fwdB_EX                forwarding selects (combinational)
//   stall_cnt, flush_cnt, mem_err   registered status
module hazard_ctrl #(
  parameter int CntW    = 32,
  parameter int MaxWait = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      rs1_ID,
  input  logic [4:0]      rs2_ID,
  input  logic            rs1_used_ID,
  input  logic            rs2_used_ID,
  input  logic [4:0]      rs1_EX,
  input  logic [4:0]      rs2_EX,
  input  logic [4:0]      rd_EX,
  input  logic            RegWEn_EX,
  input  logic [1:0]      WBSel_EX,
  input  logic            PCSel_EX,
  input  logic [4:0]      rd_MEM,
  input  logic            RegWEn_MEM,
  input  logic [4:0]      rd_WB,
  input  logic            RegWEn_WB,
  input  logic            dmem_req,
  input  logic            dmem_ready,
  output logic            pc_en,
  output logic            en_IF_ID,
  output logic            en_ID_EX,
  output logic            en_EX_MEM,
  output logic            flush_IF_ID,
  output logic            flush_ID_EX,
  output logic [1:0]      fwdA_EX,
  output logic [1:0]      fwdB_EX,
  output logic [CntW-1:0] stall_cnt,
  output logic [CntW-1:0] flush_cnt,
  output logic            mem_err
);

  localparam int WaitW = $clog2(MaxWait + 1);

  typedef enum logic {ST_RUN, ST_WAIT} state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CntW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CntW-1:0]   flush_cnt_q, flush_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic freeze;
  logic loaduse;

  assign freeze  = dmem_req & ~dmem_ready;
  assign loaduse = RegWEn_EX & (WBSel_EX == 2'b00) & (rd_EX != 5'd0) &
                   ((rs1_used_ID & (rs1_ID == rd_EX)) |
                    (rs2_used_ID & (rs2_ID == rd_EX)));

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wen_mem,
                                         input logic [4:0] rd_mem,
                                         input logic       wen_wb,
                                         input logic [4:0] rd_wb);
    if (wen_mem && rd_mem != 5'd0 && rd_mem == rs)
      return 2'b01;
    else if (wen_wb && rd_wb != 5'd0 && rd_wb == rs)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // Pipeline control; reset forces the free-running defaults.
  always_comb begin
    pc_en       = 1'b1;
    en_IF_ID    = 1'b1;
    en_ID_EX    = 1'b1;
    en_EX_MEM   = 1'b1;
    flush_IF_ID = 1'b0;
    flush_ID_EX = 1'b0;
    fwdA_EX     = 2'b00;
    fwdB_EX     = 2'b00;
    if (!rst_i) begin
      fwdA_EX = fwd_sel(rs1_EX, RegWEn_MEM, rd_MEM, RegWEn_WB, rd_WB);
      fwdB_EX = fwd_sel(rs2_EX, RegWEn_MEM, rd_MEM, RegWEn_WB, rd_WB);
      if (freeze) begin
        // Whole pipe holds; redirect and load-use are re-seen after the wait.
        pc_en     = 1'b0;
        en_IF_ID  = 1'b0;
        en_ID_EX  = 1'b0;
        en_EX_MEM = 1'b0;
      end else if (PCSel_EX) begin
        // ID holds a wrong-path instruction, so its load-use is moot.
        flush_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end else if (loaduse) begin
        pc_en       = 1'b0;
        en_IF_ID    = 1'b0;
        flush_ID_EX = 1'b1;
      end
    end
  end

  // Next-state for the wait FSM, counters and sticky flag.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WaitW'(1);
        end
      end
      ST_WAIT: begin
        if (freeze) begin
          if (wait_cnt_q != WaitW'(MaxWait))
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          if (wait_cnt_q == WaitW'(MaxWait - 1))
            mem_err_d = 1'b1;
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    if ((freeze || (loaduse && !PCSel_EX)) && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CntW'(1);
    if (PCSel_EX && !freeze && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic        rs1_used_ID, rs2_used_ID, RegWEn_EX, PCSel_EX;
  logic        RegWEn_MEM, RegWEn_WB, dmem_req, dmem_ready;
  logic [1:0]  WBSel_EX;
  logic        pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, flush_IF_ID, flush_ID_EX;
  logic [1:0]  fwdA_EX, fwdB_EX;
  logic [31:0] stall_cnt, flush_cnt;
  logic        mem_err;
  logic [5:0]  ctl;

  int vectors = 0;
  int errors  = 0;

  // {pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, flush_IF_ID, flush_ID_EX}
  assign ctl = {pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, flush_IF_ID, flush_ID_EX};

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.CntW(32), .MaxWait(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
    .RegWEn_EX(RegWEn_EX), .WBSel_EX(WBSel_EX), .PCSel_EX(PCSel_EX),
    .rd_MEM(rd_MEM), .RegWEn_MEM(RegWEn_MEM),
    .rd_WB(rd_WB), .RegWEn_WB(RegWEn_WB),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .en_IF_ID(en_IF_ID), .en_ID_EX(en_ID_EX), .en_EX_MEM(en_EX_MEM),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .fwdA_EX(fwdA_EX), .fwdB_EX(fwdB_EX),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_ID = 0; rs2_ID = 0; rs1_used_ID = 0; rs2_used_ID = 0;
    rs1_EX = 0; rs2_EX = 0; rd_EX = 0; RegWEn_EX = 0; WBSel_EX = 2'b01;
    PCSel_EX = 0; rd_MEM = 0; RegWEn_MEM = 0; rd_WB = 0; RegWEn_WB = 0;
    dmem_req = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1;
    dmem_req = 1; dmem_ready = 0; PCSel_EX = 1;
    rs1_EX = 7; rd_MEM = 7; RegWEn_MEM = 1;
    #1;
    vectors++;
    if (ctl !== 6'b111100) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b111100); end
    vectors++;
    if (fwdA_EX !== 2'b00) begin errors++; $display("FAIL reset_fwdA: got %b expected 00", fwdA_EX); end
    tick();
    vectors++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || mem_err !== 0) begin
      errors++; $display("FAIL reset_regs: got stall=%0d flush=%0d err=%b expected 0 0 0", stall_cnt, flush_cnt, mem_err);
    end
    clear_inputs();
    rst_i = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    RegWEn_EX = 1; WBSel_EX = 2'b00; rd_EX = 5;
    rs1_ID = 5; rs1_used_ID = 1;
    #1;
    vectors++;
    if (ctl !== 6'b001101) begin errors++; $display("FAIL loaduse_rs1_ctl: got %b expected %b", ctl, 6'b001101); end
    tick();
    vectors++;
    if (stall_cnt !== 1) begin errors++; $display("FAIL loaduse_stall1: got %0d expected 1", stall_cnt); end
    // load has advanced; EX now holds the bubble
    RegWEn_EX = 0; WBSel_EX = 2'b01; rd_EX = 0;
    #1;
    vectors++;
    if (ctl !== 6'b111100) begin errors++; $display("FAIL loaduse_release_ctl: got %b expected %b", ctl, 6'b111100); end
    tick();
    // rd_EX = 0 never stalls
    RegWEn_EX = 1; WBSel_EX = 2'b00; rd_EX = 0; rs1_ID = 0; rs1_used_ID = 1;
    #1;
    vectors++;
    if (ctl !== 6'b111100) begin errors++; $display("FAIL loaduse_x0_ctl: got %b expected %b", ctl, 6'b111100); end
    tick();
    vectors++;
    if (stall_cnt !== 1) begin errors++; $display("FAIL loaduse_x0_cnt: got %0d expected 1", stall_cnt); end
    // match through rs2
    rd_EX = 9; rs1_ID = 3; rs2_ID = 9; rs2_used_ID = 1;
    #1;
    vectors++;
    if (ctl !== 6'b001101) begin errors++; $display("FAIL loaduse_rs2_ctl: got %b expected %b", ctl, 6'b001101); end
    tick();
    // matching rs2 that is not read does not stall
    rs2_used_ID = 0;
    #1;
    vectors++;
    if (ctl !== 6'b111100) begin errors++; $display("FAIL loaduse_unused_ctl: got %b expected %b", ctl, 6'b111100); end
    // ALU result in EX is forwarded, not stalled
    rs2_used_ID = 1; WBSel_EX = 2'b01;
    #1;
    vectors++;
    if (ctl !== 6'b111100) begin errors++; $display("FAIL loaduse_alu_ctl: got %b expected %b", ctl, 6'b111100); end
    tick();
    vectors++;
    if (stall_cnt !== 2) begin errors++; $display("FAIL loaduse_stall2: got %0d expected 2", stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    RegWEn_EX = 1; WBSel_EX = 2'b00; rd_EX = 5; rs1_ID = 5; rs1_used_ID = 1;
    PCSel_EX = 1;
    #1;
    vectors++;
    if (ctl !== 6'b111111) begin errors++; $display("FAIL branch_ctl: got %b expected %b", ctl, 6'b111111); end
    tick();
    vectors++;
    if (flush_cnt !== 1 || stall_cnt !== 0) begin
      errors++; $display("FAIL branch_cnt: got flush=%0d stall=%0d expected 1 0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    rs1_EX = 7; rs2_EX = 9; rd_MEM = 7; rd_WB = 7; RegWEn_MEM = 1; RegWEn_WB = 1;
    #1;
    vectors++;
    if (fwdA_EX !== 2'b01) begin errors++; $display("FAIL fwdA_mem_prio: got %b expected 01", fwdA_EX); end
    vectors++;
    if (fwdB_EX !== 2'b00) begin errors++; $display("FAIL fwdB_none: got %b expected 00", fwdB_EX); end
    RegWEn_MEM = 0;
    #1;
    vectors++;
    if (fwdA_EX !== 2'b10) begin errors++; $display("FAIL fwdA_wb: got %b expected 10", fwdA_EX); end
    RegWEn_MEM = 1; rs1_EX = 0; rd_MEM = 0; rd_WB = 0;
    #1;
    vectors++;
    if (fwdA_EX !== 2'b00) begin errors++; $display("FAIL fwdA_x0: got %b expected 00", fwdA_EX); end
    rd_MEM = 9; rd_WB = 9;
    #1;
    vectors++;
    if (fwdB_EX !== 2'b01 || fwdA_EX !== 2'b00) begin
      errors++; $display("FAIL fwdB_mem_prio: got A=%b B=%b expected A=00 B=01", fwdA_EX, fwdB_EX);
    end
    RegWEn_MEM = 0;
    #1;
    vectors++;
    if (fwdB_EX !== 2'b10) begin errors++; $display("FAIL fwdB_wb: got %b expected 10", fwdB_EX); end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    dmem_req = 1; dmem_ready = 0; PCSel_EX = 1;
    rs1_EX = 3; rd_MEM = 3; RegWEn_MEM = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (ctl !== 6'b000000) begin errors++; $display("FAIL wait_ctl[%0d]: got %b expected %b", i, ctl, 6'b000000); end
      vectors++;
      if (fwdA_EX !== 2'b01) begin errors++; $display("FAIL wait_fwd[%0d]: got %b expected 01", i, fwdA_EX); end
      tick();
    end
    vectors++;
    if (stall_cnt !== 5 || flush_cnt !== 0 || mem_err !== 0) begin
      errors++; $display("FAIL wait_cnt: got stall=%0d flush=%0d err=%b expected 5 0 0", stall_cnt, flush_cnt, mem_err);
    end
    dmem_ready = 1;
    #1;
    vectors++;
    if (ctl !== 6'b111111) begin errors++; $display("FAIL wait_ready_ctl: got %b expected %b", ctl, 6'b111111); end
    tick();
    vectors++;
    if (stall_cnt !== 5 || flush_cnt !== 1) begin
      errors++; $display("FAIL wait_ready_cnt: got stall=%0d flush=%0d expected 5 1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      vectors++;
      if (mem_err !== (i >= 16)) begin
        errors++; $display("FAIL timeout_err[%0d]: got %b expected %b", i, mem_err, (i >= 16));
      end
    end
    dmem_ready = 1; dmem_req = 0;
    tick();
    tick();
    vectors++;
    if (mem_err !== 1 || stall_cnt !== 20) begin
      errors++; $display("FAIL timeout_sticky: got err=%b stall=%0d expected 1 20", mem_err, stall_cnt);
    end
    rst_i = 1;
    #1;
    vectors++;
    if (mem_err !== 0) begin errors++; $display("FAIL timeout_reset: got %b expected 0", mem_err); end
    tick();
    rst_i = 0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    tick(); tick(); tick();
    vectors++;
    if (stall_cnt !== 3) begin errors++; $display("FAIL midwait_pre: got %0d expected 3", stall_cnt); end
    #3;
    rst_i = 1;
    #1;
    vectors++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || mem_err !== 0) begin
      errors++; $display("FAIL midwait_async: got stall=%0d flush=%0d err=%b expected 0 0 0", stall_cnt, flush_cnt, mem_err);
    end
    vectors++;
    if (ctl !== 6'b111100) begin errors++; $display("FAIL midwait_rst_ctl: got %b expected %b", ctl, 6'b111100); end
    tick();
    dmem_req = 0; dmem_ready = 0;
    rst_i = 0;
    #1;
    vectors++;
    if (ctl !== 6'b111100) begin errors++; $display("FAIL midwait_after_ctl: got %b expected %b", ctl, 6'b111100); end
    tick();
    vectors++;
    if (stall_cnt !== 0) begin errors++; $display("FAIL midwait_after_cnt: got %0d expected 0", stall_cnt); end
  endtask

  initial begin
    clear_inputs();
    rst_i = 1;
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_forwarding();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
